// File: rtl/br_seq.sv
// Control-flow sequencer for BR, JMP/RET and JSR/JSRR: owns the PC, requests
// branch-enable evaluation and drives the register-file read/R7 write ports.
module br_seq #(
    parameter logic [15:0] PC_RESET = 16'h3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IR,
    input  logic        Ben,
    input  logic [15:0] BaseR_Val,
    output logic        Load_BEN,
    output logic [2:0]  Rd_Sel,
    output logic        R7_Wr,
    output logic [15:0] R7_Data,
    output logic [15:0] PC,
    output logic        Busy,
    output logic        Done,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        IDLE,
        BEN_LD,
        BR_EVAL,
        JMP_RD,
        JSR_SAVE,
        JSR_JUMP,
        DONE
    } state_t;

    state_t      r_state;
    logic [11:0] r_ir;
    logic [15:0] r_pc;
    logic [15:0] r_target;
    logic        r_load_ben;
    logic [2:0]  r_rd_sel;
    logic        r_r7_wr;
    logic        r_done;
    logic        r_illegal;

    logic [15:0] w_br_off;
    logic [15:0] w_jsr_off;

    assign w_br_off  = {{7{r_ir[8]}}, r_ir[8:0]};
    assign w_jsr_off = {{5{r_ir[10]}}, r_ir[10:0]};

    // Strobes are registered: they are set on the edge that enters the state
    // they belong to, so they are high for exactly the cycle spent there.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_ir       <= '0;
            r_pc       <= PC_RESET;
            r_target   <= '0;
            r_load_ben <= 1'b0;
            r_rd_sel   <= 3'd0;
            r_r7_wr    <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_load_ben <= 1'b0;
            r_rd_sel   <= 3'd0;
            r_r7_wr    <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_ir <= IR[11:0];
                        r_pc <= r_pc + 16'd1;
                        case (IR[15:12])
                            4'b0000: begin
                                r_state    <= BEN_LD;
                                r_load_ben <= 1'b1;
                            end
                            4'b1100: begin
                                r_state  <= JMP_RD;
                                r_rd_sel <= IR[8:6];
                            end
                            4'b0100: begin
                                r_state  <= JSR_SAVE;
                                r_rd_sel <= IR[8:6];
                                r_r7_wr  <= 1'b1;
                            end
                            default: begin
                                r_illegal <= 1'b1;
                                r_done    <= 1'b1;
                            end
                        endcase
                    end
                end
                BEN_LD: r_state <= BR_EVAL;
                BR_EVAL: begin
                    if (Ben)
                        r_pc <= r_pc + w_br_off;
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                JMP_RD: begin
                    r_pc    <= BaseR_Val;
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                JSR_SAVE: begin
                    // BaseR_Val still holds the pre-write R7 here, which JSRR R7 relies on
                    r_target <= BaseR_Val;
                    r_state  <= JSR_JUMP;
                end
                JSR_JUMP: begin
                    r_pc    <= r_ir[11] ? (r_pc + w_jsr_off) : r_target;
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Load_BEN = r_load_ben;
    assign Rd_Sel   = r_rd_sel;
    assign R7_Wr    = r_r7_wr;
    assign R7_Data  = r_pc;
    assign PC       = r_pc;
    assign Busy     = (r_state != IDLE);
    assign Done     = r_done;
    assign Illegal  = r_illegal;

endmodule

// File: tb/tb_br_seq.sv
// Bench for br_seq: directed vector table, hand-written corner sequences and
// randomized instructions checked against an instruction-level PC model.
module tb_br_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] IR = '0;
    logic        Ben = 1'b0;
    logic [15:0] BaseR_Val;
    logic        Load_BEN, R7_Wr, Busy, Done, Illegal;
    logic [2:0]  Rd_Sel;
    logic [15:0] R7_Data, PC;

    br_seq #(.PC_RESET(16'h3000)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .Ben(Ben),
        .BaseR_Val(BaseR_Val), .Load_BEN(Load_BEN), .Rd_Sel(Rd_Sel),
        .R7_Wr(R7_Wr), .R7_Data(R7_Data), .PC(PC), .Busy(Busy),
        .Done(Done), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    logic [15:0] regs [8];
    always_comb BaseR_Val = regs[Rd_Sel];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] m_pc;

    int          obs_lat, obs_nlb, obs_nr7, obs_nill;
    logic [15:0] obs_pc, obs_r7d;
    logic [2:0]  obs_rd1;
    logic        obs_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge Clk);
        Reset = 1'b1; Start = 1'b0;
        @(negedge Clk);
        if (check) begin
            chk("rst.pc", PC, 16'h3000);
            chk("rst.r7data", R7_Data, 16'h3000);
            chk("rst.strobes", {Busy, Done, Illegal, Load_BEN, R7_Wr}, 5'b0);
            chk("rst.rdsel", Rd_Sel, 3'd0);
        end
        Reset = 1'b0;
        m_pc = 16'h3000;
    endtask

    // Issue one instruction; optionally keep Start high with junk while busy.
    task automatic run_instr(input logic [15:0] ir, input logic ben_v, input bit hold);
        bit          done, pend;
        logic [15:0] pend_d;
        done = 0; pend = 0; pend_d = '0;
        obs_lat = 0; obs_nlb = 0; obs_nr7 = 0; obs_nill = 0;
        obs_r7d = '0; obs_rd1 = '0; obs_busy = 1'b0;
        @(negedge Clk);
        Start = 1'b1; IR = ir; Ben = ben_v;
        for (int k = 1; k <= 8 && !done; k++) begin
            @(negedge Clk);
            if (pend) begin regs[7] = pend_d; pend = 0; end
            if (k == 1) obs_rd1 = Rd_Sel;
            if (Load_BEN) obs_nlb += (k == 1) ? 1 : 10;
            if (Illegal) obs_nill++;
            if (R7_Wr) begin obs_nr7++; obs_r7d = R7_Data; pend = 1; pend_d = R7_Data; end
            if (Done) begin
                done = 1; obs_lat = k; obs_busy = Busy; Start = 1'b0;
            end else begin
                Start = hold; IR = {4'h1, 12'(k)};
            end
        end
        Start = 1'b0;
        obs_pc = PC;
    endtask

    task automatic compare(input string tag, input logic [15:0] ir, input logic [15:0] e_pc,
                           input int e_lat, input bit e_ill, input bit e_r7w, input logic [15:0] e_r7d);
        bit has_rd;
        has_rd = (ir[15:12] == 4'hC) || (ir[15:12] == 4'h4);
        chk({tag, ".latency"}, obs_lat, e_lat);
        chk({tag, ".pc"}, obs_pc, e_pc);
        chk({tag, ".illegal"}, obs_nill, e_ill);
        chk({tag, ".busy_at_done"}, obs_busy, !e_ill);
        chk({tag, ".load_ben"}, obs_nlb, (ir[15:12] == 4'h0) ? 1 : 0);
        chk({tag, ".rd_sel"}, obs_rd1, has_rd ? ir[8:6] : 3'd0);
        chk({tag, ".r7_wr_count"}, obs_nr7, e_r7w);
        if (e_r7w) chk({tag, ".r7_data"}, obs_r7d, e_r7d);
    endtask

    function automatic int sext(input logic [15:0] v, input int bits);
        int u;
        u = int'(v) & ((1 << bits) - 1);
        return (u >= (1 << (bits - 1))) ? u - (1 << bits) : u;
    endfunction

    // Instruction-level model: what PC/R7 should become after one instruction.
    task automatic model(input logic [15:0] ir, input logic ben_v, output logic [15:0] e_pc,
                         output int e_lat, output bit e_ill, output bit e_r7w, output logic [15:0] e_r7d);
        int npc;
        npc = (int'(m_pc) + 1) % 65536;
        e_ill = 0; e_r7w = 0; e_r7d = '0;
        case (ir[15:12])
            4'h0: begin
                e_lat = 3;
                e_pc = ben_v ? 16'((npc + sext(ir, 9)) & 32'hFFFF) : 16'(npc);
            end
            4'hC: begin e_lat = 2; e_pc = regs[ir[8:6]]; end
            4'h4: begin
                e_lat = 3; e_r7w = 1; e_r7d = 16'(npc);
                e_pc = ir[11] ? 16'((npc + sext(ir, 11)) & 32'hFFFF) : regs[ir[8:6]];
            end
            default: begin e_lat = 1; e_ill = 1; e_pc = 16'(npc); end
        endcase
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        ben;
        logic [15:0] r7;
        bit          hold;
        logic [15:0] e_pc;
        int          e_lat;
        bit          e_ill;
        bit          e_r7w;
        logic [15:0] e_r7d;
    } vec_t;

    vec_t tbl [7];
    logic [3:0] ill_ops [13];

    initial begin
        logic [15:0] ir, w, e_pc, e_r7d;
        logic        b;
        int          e_lat, sel;
        bit          e_ill, e_r7w, hold;
        bit          saw_done, pc_moved;

        for (int i = 0; i < 8; i++) regs[i] = 16'h1000 * 16'(i);
        ill_ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};

        tbl[0] = '{16'h0E05, 1'b1, 16'h0000, 1'b1, 16'h3006, 3, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{16'h0E05, 1'b0, 16'h0000, 1'b0, 16'h3001, 3, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{16'h01FF, 1'b1, 16'h0000, 1'b0, 16'h3000, 3, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{16'hC1C0, 1'b0, 16'h4000, 1'b1, 16'h4000, 2, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{16'h41C0, 1'b0, 16'h5000, 1'b1, 16'h5000, 3, 1'b0, 1'b1, 16'h3001};
        tbl[5] = '{16'h1000, 1'b0, 16'h0000, 1'b0, 16'h3001, 1, 1'b1, 1'b0, 16'h0000};
        tbl[6] = '{16'h4805, 1'b0, 16'h0000, 1'b0, 16'h3006, 3, 1'b0, 1'b1, 16'h3001};

        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            do_reset(0);
            regs[7] = tbl[i].r7;
            run_instr(tbl[i].ir, tbl[i].ben, tbl[i].hold);
            compare($sformatf("vec%0d", i), tbl[i].ir, tbl[i].e_pc, tbl[i].e_lat,
                    tbl[i].e_ill, tbl[i].e_r7w, tbl[i].e_r7d);
        end

        // JSR offset wrapping through 0000
        do_reset(0);
        regs[7] = 16'h0000;
        run_instr(16'hC1C0, 1'b0, 1'b0);
        compare("wrap.jmp", 16'hC1C0, 16'h0000, 2, 1'b0, 1'b0, 16'h0000);
        run_instr(16'h4FFF, 1'b0, 1'b0);
        compare("wrap.jsr", 16'h4FFF, 16'h0000, 3, 1'b0, 1'b1, 16'h0001);

        // Reset landing in JSR_SAVE must cancel the sequence
        do_reset(0);
        @(negedge Clk);
        Start = 1'b1; IR = 16'h41C0;
        @(negedge Clk);
        Start = 1'b0;
        chk("rstmid.r7wr_before", R7_Wr, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rstmid.r7wr", R7_Wr, 1'b0);
        chk("rstmid.pc", PC, 16'h3000);
        chk("rstmid.busy", Busy, 1'b0);
        saw_done = 0; pc_moved = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (Done || R7_Wr || Busy) saw_done = 1;
            if (PC !== 16'h3000) pc_moved = 1;
        end
        chk("rstmid.no_activity", saw_done, 1'b0);
        chk("rstmid.pc_stable", pc_moved, 1'b0);

        // Randomized instruction stream against the model
        do_reset(0);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
            sel = $urandom_range(0, 4);
            w = 16'($urandom);
            case (sel)
                0: ir = {4'h0, w[11:0]};
                1: ir = {4'hC, 3'b000, w[8:6], 6'b0};
                2: ir = {4'h4, 1'b1, w[10:0]};
                3: ir = {4'h4, 3'b000, w[8:6], 6'b0};
                default: ir = {ill_ops[$urandom_range(0, 12)], w[11:0]};
            endcase
            b = 1'($urandom);
            hold = 1'($urandom);
            model(ir, b, e_pc, e_lat, e_ill, e_r7w, e_r7d);
            run_instr(ir, b, hold);
            compare($sformatf("rnd%0d", n), ir, e_pc, e_lat, e_ill, e_r7w, e_r7d);
            m_pc = e_pc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
